alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 16 +
 rtl/alu_seq.sv | 113 +++++++++++
 tb/tb_alu_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and registered result bundle for alu_seq
interface alu_seq_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C1;
  logic [2:0]       O;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] H;
  logic             C2;
  logic             Z;
  logic             out_valid;
  modport master (output A, B, C1, O, in_valid, input in_ready, S, H, C2, Z, out_valid);
  modport slave  (input A, B, C1, O, in_valid, output in_ready, S, H, C2, Z, out_valid);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU ops plus a WIDTH-cycle shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, h_q, h_d;
  logic             c2_q, c2_d, z_q, z_d, ov_q, ov_d;
  logic [W2-1:0]    mcand_q, mcand_d, acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_s;
  logic             alu_c;
  logic [WIDTH:0]   add_r, sub_r;
  logic             accept;
  // Ready is withheld while in reset so nothing is accepted before release.
  assign bus.in_ready  = rst_n && state_q == IDLE;
  assign bus.S         = s_q;
  assign bus.H         = h_q;
  assign bus.C2        = c2_q;
  assign bus.Z         = z_q;
  assign bus.out_valid = ov_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign acc_step      = mplier_q[0] ? acc_q + mcand_q : acc_q;
  // Single-cycle result for opcodes 000-110; the borrow is the sign bit of the widened difference.
  always_comb begin
    add_r = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.C1};
    sub_r = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.C1};
    alu_s = '0;
    alu_c = 1'b0;
    case (bus.O)
      3'd0: {alu_c, alu_s} = add_r;
      3'd1: {alu_c, alu_s} = sub_r;
      3'd2: alu_s = bus.A & bus.B;
      3'd3: alu_s = bus.A | bus.B;
      3'd4: alu_s = bus.A ^ bus.B;
      3'd5: {alu_c, alu_s} = {bus.A, bus.C1};
      3'd6: {alu_s, alu_c} = {bus.C1, bus.A};
      default: ;
    endcase
  end
  // Next-state: accept in IDLE, or one shift-add step per cycle in MUL with the result on the last step.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    h_d      = h_q;
    c2_d     = c2_q;
    z_d      = z_q;
    ov_d     = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && accept && bus.O == 3'd7) begin
      mcand_d  = {{WIDTH{1'b0}}, bus.A};
      mplier_d = bus.B;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = MUL;
    end else if (state_q == IDLE && accept) begin
      s_d  = alu_s;
      h_d  = '0;
      c2_d = alu_c;
      z_d  = alu_s == '0;
      ov_d = 1'b1;
    end else if (state_q == MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = IDLE;
        s_d     = acc_step[WIDTH-1:0];
        h_d     = acc_step[W2-1:WIDTH];
        c2_d    = 1'b0;
        z_d     = acc_step == '0;
        ov_d    = 1'b1;
      end
    end
  end
  // All state, including the multiplier datapath, clears asynchronously so reset aborts a MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      h_q      <= '0;
      c2_q     <= 1'b0;
      z_q      <= 1'b0;
      ov_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      h_q      <= h_d;
      c2_q     <= c2_d;
      z_q      <= z_d;
      ov_q     <= ov_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (WIDTH=4)
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses;
  alu_seq_if #(.WIDTH(4)) bus ();
  alu_seq #(.WIDTH(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic c1);
    bus.O = o;
    bus.A = a;
    bus.B = b;
    bus.C1 = c1;
    bus.in_valid = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                      input logic c1, input logic [3:0] es, input logic ec, input logic ez);
    issue(o, a, b, c1);
    tick();
    chk({tag, ".ov"}, bus.out_valid, 1'b1);
    chk({tag, ".S"}, bus.S, es);
    chk({tag, ".H"}, bus.H, 4'h0);
    chk({tag, ".C2"}, bus.C2, ec);
    chk({tag, ".Z"}, bus.Z, ez);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.O = 3'd0;
    bus.A = 4'h0;
    bus.B = 4'h0;
    bus.C1 = 1'b0;
    #2;
    chk("rst.S", bus.S, 4'h0);
    chk("rst.H", bus.H, 4'h0);
    chk("rst.C2", bus.C2, 1'b0);
    chk("rst.Z", bus.Z, 1'b0);
    chk("rst.ov", bus.out_valid, 1'b0);
    chk("rst.rdy", bus.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel.rdy", bus.in_ready, 1'b1);
    step("add_ff", 3'd0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("add_ff.pulse", bus.out_valid, 1'b0);
    chk("add_ff.hold", bus.S, 4'h0);
    step("sub_35", 3'd1, 4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0);
    step("sub_53", 3'd1, 4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0);
    step("sub_551", 3'd1, 4'h5, 4'h5, 1'b1, 4'hF, 1'b1, 1'b0);
    step("add_781", 3'd0, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1);
    step("and", 3'd2, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0);
    step("or", 3'd3, 4'hC, 4'hA, 1'b1, 4'hE, 1'b0, 1'b0);
    step("xor", 3'd4, 4'hC, 4'hA, 1'b0, 4'h6, 1'b0, 1'b0);
    step("shl", 3'd5, 4'h9, 4'h0, 1'b1, 4'h3, 1'b1, 1'b0);
    step("shr", 3'd6, 4'h9, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("shr.pulse", bus.out_valid, 1'b0);
    issue(3'd7, 4'hF, 4'hF, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mulff.busy%0d", i), bus.in_ready, 1'b0);
      chk($sformatf("mulff.ov%0d", i), bus.out_valid, 1'b0);
      tick();
    end
    chk("mulff.ov", bus.out_valid, 1'b1);
    chk("mulff.H", bus.H, 4'hE);
    chk("mulff.S", bus.S, 4'h1);
    chk("mulff.C2", bus.C2, 1'b0);
    chk("mulff.Z", bus.Z, 1'b0);
    chk("mulff.rdy", bus.in_ready, 1'b1);
    step("add_b2b", 3'd0, 4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0);
    issue(3'd7, 4'h0, 4'h5, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("mul0.ov", bus.out_valid, 1'b1);
    chk("mul0.HS", {bus.H, bus.S}, 8'h00);
    chk("mul0.Z", bus.Z, 1'b1);
    issue(3'd7, 4'h7, 4'h3, 1'b0);
    tick();
    issue(3'd0, 4'h1, 4'h1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      pulses += int'(bus.out_valid);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mulbusy.early", pulses, 0);
    chk("mulbusy.ov", bus.out_valid, 1'b1);
    chk("mulbusy.HS", {bus.H, bus.S}, 8'h15);
    tick();
    chk("mulbusy.pulse", bus.out_valid, 1'b0);
    chk("mulbusy.hold", {bus.H, bus.S}, 8'h15);
    issue(3'd7, 4'h7, 4'h3, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort.HS", {bus.H, bus.S}, 8'h00);
    chk("abort.C2Z", {bus.C2, bus.Z}, 2'b00);
    chk("abort.ov", bus.out_valid, 1'b0);
    chk("abort.rdy", bus.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(bus.out_valid);
    end
    chk("abort.noov", pulses, 0);
    chk("abort.rdy1", bus.in_ready, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
